// File: rtl/dma_row_writer_pkg.sv
// dma_row_writer shared types and helpers.
// State encoding, job-type constants and the row-to-block ratio.
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_PASS,
        S_FIN
    } state_e;

    localparam logic MODE_IMG = 1'b1;
    localparam logic MODE_CNN = 1'b0;

    // Number of RAM words needed to hold one row.
    function automatic int calc_blks(input int row_w, input int blk_w);
        return row_w / blk_w;
    endfunction

endpackage

// File: rtl/dma_row_writer_if.sv
// dma_row_writer job, stream and RAM bundle.
// slave: the writer itself; master: whoever drives jobs and streams.
interface dma_row_writer_if #(
    parameter int ROW_W  = 16,
    parameter int BLK_W  = 4,
    parameter int ADDR_W = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       count;
    logic              abort;

    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;

    logic [BLK_W-1:0]  word_data;
    logic              word_valid;
    logic              word_ready;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [BLK_W-1:0]  ram_wdata;
    logic              ram_stall;

    logic              busy;
    logic              done;
    logic              aborted;

    modport slave (
        input  start, mode, base_addr, count, abort,
        input  row_data, row_valid,
        output row_ready,
        input  word_data, word_valid,
        output word_ready,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_stall,
        output busy, done, aborted
    );

    modport master (
        output start, mode, base_addr, count, abort,
        output row_data, row_valid,
        input  row_ready,
        output word_data, word_valid,
        input  word_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_stall,
        input  busy, done, aborted
    );
endinterface

// File: rtl/dma_row_writer_row_serializer.sv
// Holds one captured row and walks it out LSB block first.
// last_o flags the final block so the writer knows the row is drained.
module row_serializer
    import dma_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int BLK_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic             adv_i,
    output logic [BLK_W-1:0] blk_o,
    output logic             last_o
);
    localparam int BLKS = calc_blks(ROW_W, BLK_W);
    localparam int KW   = (BLKS > 1) ? $clog2(BLKS) : 1;

    logic [ROW_W-1:0] row_q;
    logic [KW-1:0]    k_q;

    // Capture a row on load; step the block index per accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            k_q   <= '0;
        end else if (load_i) begin
            row_q <= row_i;
            k_q   <= '0;
        end else if (adv_i) begin
            k_q <= last_o ? '0 : k_q + KW'(1);
        end
    end

    assign blk_o  = row_q[int'(k_q)*BLK_W +: BLK_W];
    assign last_o = (k_q == KW'(BLKS - 1));

endmodule

// File: rtl/dma_row_writer.sv
// Writes decompressed rows (block by block) or CPU words into RAM.
// One job at a time; abort or reset drops the job mid-flight.
module dma_row_writer
    import dma_pkg::*;
#(
    parameter int ROW_W  = 16,
    parameter int BLK_W  = 4,
    parameter int ADDR_W = 16
) (
    input logic              clk,
    input logic              rst,
    dma_row_writer_if.slave  bus
);
    localparam int BLKS = calc_blks(ROW_W, BLK_W);

    if ((ROW_W % BLK_W) != 0 || BLKS < 1) begin : g_bad_width
        $error("ROW_W must be a non-zero multiple of BLK_W");
    end

    state_e            state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] off_q;
    logic [15:0]       cnt_q;
    logic [15:0]       job_q;
    logic              aborted_q;

    logic [BLK_W-1:0]  blk;
    logic              blk_last;

    logic in_fetch;
    logic in_write;
    logic in_pass;
    logic row_hs;
    logic wr_en;
    logic wr_acc;
    logic last_item;

    // Decode the current state into handshakes and the write strobe.
    always_comb begin
        in_fetch  = (state_q == S_FETCH);
        in_write  = (state_q == S_WRITE);
        in_pass   = (state_q == S_PASS);
        row_hs    = in_fetch && bus.row_valid && !bus.abort;
        wr_en     = !bus.abort &&
                    (in_write || (in_pass && bus.word_valid));
        wr_acc    = wr_en && !bus.ram_stall;
        last_item = ((job_q + 16'd1) == cnt_q);
    end

    row_serializer #(
        .ROW_W (ROW_W),
        .BLK_W (BLK_W)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (row_hs),
        .row_i  (bus.row_data),
        .adv_i  (in_write && wr_acc),
        .blk_o  (blk),
        .last_o (blk_last)
    );

    // Job sequencing: latch the job, count writes and items, finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_CNN;
            base_q    <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            job_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            if (state_q != S_IDLE && bus.abort) begin
                state_q   <= S_IDLE;
                aborted_q <= 1'b1;
            end else begin
                if (wr_acc) begin
                    off_q <= off_q + ADDR_W'(1);
                end
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            mode_q <= bus.mode;
                            base_q <= bus.base_addr;
                            cnt_q  <= bus.count;
                            off_q  <= '0;
                            job_q  <= '0;
                            if (bus.count == 16'd0) begin
                                state_q <= S_FIN;
                            end else if (bus.mode == MODE_IMG) begin
                                state_q <= S_FETCH;
                            end else begin
                                state_q <= S_PASS;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (row_hs) begin
                            state_q <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (wr_acc && blk_last) begin
                            job_q   <= job_q + 16'd1;
                            state_q <= last_item ? S_FIN : S_FETCH;
                        end
                    end
                    S_PASS: begin
                        if (wr_acc) begin
                            job_q <= job_q + 16'd1;
                            if (last_item) begin
                                state_q <= S_FIN;
                            end
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.row_ready  = in_fetch && !bus.abort;
    assign bus.word_ready = in_pass && !bus.ram_stall && !bus.abort;
    assign bus.ram_en     = wr_en;
    assign bus.ram_we     = wr_en;
    assign bus.ram_addr   = wr_en ? (base_q + off_q) : '0;
    assign bus.ram_wdata  = !wr_en ? '0 :
                            (mode_q == MODE_IMG) ? blk : bus.word_data;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_FIN) && !bus.abort;
    assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_dma_row_writer.sv
// Directed bench for dma_row_writer with a write-list reference model.
module tb_dma_row_writer;
    localparam int ROW_W  = 16;
    localparam int BLK_W  = 4;
    localparam int ADDR_W = 16;
    localparam int BLKS   = ROW_W / BLK_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_row_writer_if #(
        .ROW_W(ROW_W), .BLK_W(BLK_W), .ADDR_W(ADDR_W)
    ) bus ();

    dma_row_writer #(
        .ROW_W(ROW_W), .BLK_W(BLK_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  abort_cnt = 0;
    int  start_cyc;
    int  dc;
    int  t_unst;
    int  t_st;
    int  li;
    int  wbase;
    int  dbase;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference: item i of a job lands at base + i*BLKS + k.
    task automatic model_row(input logic [15:0] base, input int idx,
                             input logic [15:0] row, input int nblk);
        wr_t w;
        for (int k = 0; k < nblk; k++) begin
            w.a = base + 16'(idx * BLKS + k);
            w.d = 4'((row >> (4 * k)) & 16'hF);
            exp_q.push_back(w);
        end
    endtask

    task automatic model_word(input logic [15:0] base, input int idx,
                              input logic [3:0] wd);
        wr_t w;
        w.a = base + 16'(idx);
        w.d = wd;
        exp_q.push_back(w);
    endtask

    // Compare every accepted RAM write against the model queue.
    always @(negedge clk) begin
        wr_t w;
        wr_t e;
        if (!rst && bus.ram_en && !bus.ram_stall) begin
            w.a = bus.ram_addr;
            w.d = bus.ram_wdata;
            log_q.push_back(w);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got %h/%h want none",
                         bus.ram_addr, bus.ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("ram_write", {11'h0, bus.ram_we, w},
                    {11'h0, 1'b1, e});
            end
        end
        if (!rst && bus.done) done_cnt++;
        if (!rst && bus.aborted) abort_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic m, input logic [15:0] b,
                             input logic [15:0] c);
        bus.start = 1'b1;
        bus.mode = m;
        bus.base_addr = b;
        bus.count = c;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] r);
        logic hs;
        hs = 1'b0;
        bus.row_data = r;
        bus.row_valid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = bus.row_ready;
            tick();
        end
        bus.row_valid = 1'b0;
        if (!hs) begin
            n_chk++;
            $display("FAIL row_timeout: got no row_ready want handshake");
        end
    endtask

    task automatic send_word(input logic [3:0] wd);
        logic hs;
        hs = 1'b0;
        bus.word_data = wd;
        bus.word_valid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            hs = bus.word_ready;
            tick();
        end
        bus.word_valid = 1'b0;
        if (!hs) begin
            n_chk++;
            $display("FAIL word_timeout: got no word_ready want handshake");
        end
    endtask

    task automatic wait_done(output int d);
        logic seen;
        seen = 1'b0;
        d = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                d = cyc - start_cyc;
            end
            tick();
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL done_timeout: got no done want pulse");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.base_addr = '0;
        bus.count = '0;
        bus.abort = 1'b0;
        bus.row_data = '0;
        bus.row_valid = 1'b0;
        bus.word_data = '0;
        bus.word_valid = 1'b0;
        bus.ram_stall = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_flags", {25'h0, bus.ram_en, bus.ram_we, bus.row_ready,
            bus.word_ready, bus.busy, bus.done, bus.aborted}, 32'h0);
        chk("rst_addr", {16'h0, bus.ram_addr}, 32'h0);
        chk("rst_wdata", {28'h0, bus.ram_wdata}, 32'h0);
        tick();
        rst = 1'b0;

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ignored", {30'h0, bus.aborted, bus.busy}, 32'h0);
        tick();

        model_row(16'h0010, 0, 16'hABCD, BLKS);
        model_row(16'h0010, 1, 16'h1234, BLKS);
        li = log_q.size();
        start_job(1'b1, 16'h0010, 16'd2);
        send_row(16'hABCD);
        send_row(16'h1234);
        wait_done(dc);
        chk("img_done_lat", dc, 11);
        chk("img_wr_count", log_q.size() - li, 8);
        chk("img_first", {12'h0, log_q[li]}, {12'h0, 16'h0010, 4'hD});
        chk("img_last", {12'h0, log_q[li+7]}, {12'h0, 16'h0017, 4'h1});
        @(negedge clk);
        chk("img_busy_after", {31'h0, bus.busy}, 32'h0);
        tick();

        model_row(16'h0100, 0, 16'h5A3C, BLKS);
        start_job(1'b1, 16'h0100, 16'd1);
        send_row(16'h5A3C);
        wait_done(t_unst);
        chk("unstalled_lat", t_unst, 6);

        model_row(16'h0100, 0, 16'h5A3C, BLKS);
        li = log_q.size();
        start_job(1'b1, 16'h0100, 16'd1);
        send_row(16'h5A3C);
        tick();
        bus.ram_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", {11'h0, bus.ram_en, bus.ram_addr,
                bus.ram_wdata}, {11'h0, 1'b1, 16'h0101, 4'h3});
            tick();
        end
        bus.ram_stall = 1'b0;
        wait_done(t_st);
        chk("stall_lat", t_st, 9);
        chk("stall_delta", t_st - t_unst, 3);
        chk("stall_wr_count", log_q.size() - li, 4);

        for (int i = 0; i < 4; i++)
            model_word(16'hFFFE, i, 4'(i + 1));
        li = log_q.size();
        start_job(1'b0, 16'hFFFE, 16'd4);
        for (int i = 0; i < 4; i++) send_word(4'(i + 1));
        wait_done(dc);
        chk("cnn_done_lat", dc, 5);
        chk("cnn_addr1", {16'h0, log_q[li+1].a}, 32'h0000FFFF);
        chk("cnn_addr2", {16'h0, log_q[li+2].a}, 32'h00000000);
        chk("cnn_addr3", {12'h0, log_q[li+3]}, {12'h0, 16'h0001, 4'h4});

        li = log_q.size();
        start_job(1'b1, 16'h0050, 16'd0);
        @(negedge clk);
        chk("cnt0_done", {30'h0, bus.done, bus.ram_en}, 32'h2);
        tick();
        @(negedge clk);
        chk("cnt0_idle", {30'h0, bus.done, bus.busy}, 32'h0);
        chk("cnt0_no_wr", log_q.size() - li, 0);
        tick();

        model_row(16'h0200, 0, 16'h9876, 2);
        li = log_q.size();
        dbase = done_cnt;
        start_job(1'b1, 16'h0200, 16'd1);
        send_row(16'h9876);
        tick();
        tick();
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_no_wr", {31'h0, bus.ram_en}, 32'h0);
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.count = 16'd0;
        start_cyc = cyc;
        @(negedge clk);
        chk("aborted_pulse", {30'h0, bus.aborted, bus.busy}, 32'h2);
        chk("abort_no_done", done_cnt - dbase, 0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("restart_done", {31'h0, bus.done}, 32'h1);
        chk("abort_wr_count", log_q.size() - li, 2);
        tick();

        model_row(16'h0300, 0, 16'h1111, 1);
        dbase = done_cnt;
        start_job(1'b1, 16'h0300, 16'd1);
        send_row(16'h1111);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_flags", {25'h0, bus.ram_en, bus.ram_we,
            bus.row_ready, bus.word_ready, bus.busy, bus.done,
            bus.aborted}, 32'h0);
        chk("midrst_bus", {12'h0, bus.ram_addr, bus.ram_wdata}, 32'h0);
        tick();
        rst = 1'b0;
        model_word(16'h0400, 0, 4'hA);
        model_word(16'h0400, 1, 4'hB);
        li = log_q.size();
        start_job(1'b0, 16'h0400, 16'd2);
        send_word(4'hA);
        send_word(4'hB);
        wait_done(dc);
        chk("post_rst_addr", {12'h0, log_q[li]}, {12'h0, 16'h0400, 4'hA});
        chk("post_rst_done", done_cnt - dbase, 1);

        tick();
        chk("model_drained", exp_q.size(), 0);
        chk("total_done", done_cnt, 7);
        chk("total_aborted", abort_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_row_writer.md
DMA_ROW_WRITER -- requirements
Module: dma_row_writer

Interface
REQ-001 ROW_W, 16, width of one decompressed row in bits.
REQ-002 BLK_W, 4, width of one RAM word in bits; ROW_W SHALL be an integer multiple of BLK_W, else elaboration SHALL fail.
REQ-003 ADDR_W, 16, RAM address width; BLKS = ROW_W/BLK_W is derived, not a parameter.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-007 mode  in  1  job type, latched at start: 1 = IMG (row serialisation), 0 = CNN (word pass-through).
REQ-008 base_addr  in  ADDR_W  first RAM address of the job, latched at start.
REQ-009 count  in  16  number of rows (IMG) or words (CNN) in the job, latched at start.
REQ-010 abort  in  1  terminates the current job.
REQ-011 row_data / row_valid / row_ready  in / in / out  ROW_W / 1 / 1  decompressed-row stream.
REQ-012 word_data / word_valid / word_ready  in / in / out  BLK_W / 1 / 1  CPU word stream.
REQ-013 ram_en, ram_we  out  1  RAM strobe; ram_we always equals ram_en.
REQ-014 ram_addr  out  ADDR_W; ram_wdata  out  BLK_W.
REQ-015 ram_stall  in  1  RAM not accepting this cycle.
REQ-016 busy  out  1; done, aborted  out  1  single-cycle completion pulses.

Function
REQ-017 States: IDLE, FETCH, WRITE, PASS, FIN.
REQ-018 IDLE + start: latch mode/base/count, clear offset and job counter; go FETCH (mode=1) or PASS (mode=0); count=0 goes directly to FIN with no RAM writes.
REQ-019 A RAM write is accepted in a cycle where ram_en=1 and ram_stall=0; while stalled, ram_en/addr/wdata SHALL hold stable.
REQ-020 ram_addr = base_addr + offset modulo 2^ADDR_W; offset increments by 1 per accepted write; wrap past all-ones is silent.
REQ-021 FETCH: row_ready=1; on row_valid handshake capture row, block index k=0, go WRITE next cycle.
REQ-022 WRITE: ram_en=1, ram_wdata = row bits [k*BLK_W +: BLK_W] (LSB block first); k increments per accepted write; after block BLKS-1 accepted, increment job counter, go FETCH, or FIN if job counter reaches count.
REQ-023 IMG latency: row accepted in cycle N -> first write presented in N+1; with no stall, BLKS writes in cycles N+1..N+BLKS; next row_ready in cycle N+BLKS+1.
REQ-024 PASS: word_ready = !ram_stall; ram_en = word_valid; ram_wdata = word_data (combinational path); each accepted write increments job counter; go FIN after count-th write.
REQ-025 FIN: done=1 for exactly one cycle, then IDLE.
REQ-026 abort in any non-IDLE state: no write accepted that cycle, next state IDLE, aborted=1 for one cycle, done not pulsed; abort in IDLE ignored.
REQ-027 start outside IDLE ignored; abort and start in same IDLE cycle: start wins.
REQ-028 busy=1 in every state except IDLE.
REQ-029 row_ready and word_ready SHALL be 0 outside FETCH and PASS respectively.

Reset
REQ-030 rst SHALL force IDLE and clear offset, k, job counter, captured row.
REQ-031 During and after reset: ram_en, ram_we, row_ready, word_ready, busy, done, aborted = 0; ram_addr, ram_wdata = 0.
REQ-032 rst mid-job discards the job without done or aborted pulse.

Structure
REQ-033 Package dma_pkg SHALL hold the state enum, MODE_IMG/MODE_CNN constants and the BLKS derivation function.
REQ-034 One sub-module, row_serializer, SHALL hold the captured row and block index and present the current block.

Verification
REQ-035 IMG, base=0x0010, count=2, rows 0xABCD, 0x1234, no stall -> writes D,C,B,A,4,3,2,1 at 0x0010..0x0017, done once, busy low after.
REQ-036 IMG count=1, ram_stall high 3 cycles on 2nd block -> addr/wdata held, 4 writes total, done 3 cycles later than unstalled run.
REQ-037 CNN, base=0xFFFE, count=4, words 1,2,3,4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-038 count=0 start -> no ram_en, done 1 cycle after start.
REQ-039 abort during 3rd block of a row -> exactly 2 writes of that row, aborted pulse, no done, new start accepted next cycle.
REQ-040 rst asserted mid-WRITE -> all outputs zero next cycle, IDLE, subsequent job starts at its own base_addr.
